// File: rtl/tlb_op_ctrl_pkg.sv
// Shared MMU definitions: controller state encoding, TLB instruction
// op_code values and the tlbw_choose write-select encodings.
package tlb_op_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_PROBE = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } tlb_state_t;

    typedef enum logic [1:0] {
        OP_TLBP  = 2'b00,
        OP_TLBR  = 2'b01,
        OP_TLBWI = 2'b10,
        OP_TLBWR = 2'b11
    } tlb_op_t;

    localparam logic [1:0] TLBW_NONE    = 2'b00;
    localparam logic [1:0] TLBW_INDEXED = 2'b01;
    localparam logic [1:0] TLBW_RANDOM  = 2'b10;

    // Map a latched write instruction onto the MMU write-select encoding.
    function automatic logic [1:0] tlbw_sel(input tlb_op_t op);
        logic [1:0] sel;
        sel = TLBW_NONE;
        if (op == OP_TLBWI) begin
            sel = TLBW_INDEXED;
        end else if (op == OP_TLBWR) begin
            sel = TLBW_RANDOM;
        end
        return sel;
    endfunction

endpackage

// File: rtl/tlb_op_ctrl_if.sv
// Bus between the CP0/pipeline side and the TLB operation controller.
// slave = the controller, master = whoever issues TLB instructions.
interface tlb_op_if #(
    parameter int TLBNUM = 16
);
    localparam int IW = $clog2(TLBNUM);

    logic          op_valid;
    logic [1:0]    op_code;
    logic          op_ready;
    logic          op_done;
    logic          data_req;
    logic          data_grant;
    logic          is_tlbp;
    logic [1:0]    tlbw_choose;
    logic [31:0]   tlbp_index_in;
    logic          c0_index_we;
    logic [31:0]   c0_index_wdata;
    logic          c0_tlbr_we;
    logic          wired_we;
    logic [IW-1:0] wired_val;
    logic [31:0]   c0_random;
    logic          tlb_flush;

    modport slave (
        input  op_valid, op_code, data_req, tlbp_index_in, wired_we, wired_val,
        output op_ready, op_done, data_grant, is_tlbp, tlbw_choose,
               c0_index_we, c0_index_wdata, c0_tlbr_we, c0_random, tlb_flush
    );

    modport master (
        output op_valid, op_code, data_req, tlbp_index_in, wired_we, wired_val,
        input  op_ready, op_done, data_grant, is_tlbp, tlbw_choose,
               c0_index_we, c0_index_wdata, c0_tlbr_we, c0_random, tlb_flush
    );
endinterface

// File: rtl/tlb_random.sv
// CP0 Random/Wired pair. Random counts down from TLBNUM-1 and wraps back
// to the top when the decremented value would land on Wired, so entries
// 0..Wired are never picked by TLBWR.
module tlb_random #(
    parameter int TLBNUM = 16,
    parameter int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,
    input  logic          wired_we,
    input  logic [IW-1:0] wired_val,
    output logic [IW-1:0] random
);
    localparam logic [IW-1:0] RAND_MAX = IW'(TLBNUM - 1);

    logic [IW-1:0] wired_reg;
    logic [IW-1:0] random_reg;
    logic [IW-1:0] random_next;
    logic [IW-1:0] random_dec;

    // Next Random: Wired write wins, then the saturated-Wired case, then
    // the wrapping decrement (frozen while a TLB write is using the value).
    always_comb begin
        random_dec  = random_reg - IW'(1);
        random_next = random_reg;
        if (wired_we) begin
            random_next = RAND_MAX;
        end else if (wired_reg >= RAND_MAX) begin
            random_next = RAND_MAX;
        end else if (!hold) begin
            if ((random_dec == wired_reg) || (random_reg <= wired_reg)) begin
                random_next = RAND_MAX;
            end else begin
                random_next = random_dec;
            end
        end
    end

    // Wired and Random registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wired_reg  <= '0;
            random_reg <= RAND_MAX;
        end else begin
            if (wired_we) begin
                wired_reg <= wired_val;
            end
            random_reg <= random_next;
        end
    end

    assign random = random_reg;

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBP/TLBR/TLBWI/TLBWR. Shares the MMU search port with
// load/store traffic: a probe waits for the data side to go quiet, but
// after STARVE_MAX waiting cycles it takes the port for one cycle anyway.
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter int TLBNUM     = 16,
    parameter int STARVE_MAX = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    tlb_op_if.slave   bus
);
    localparam int IW = $clog2(TLBNUM);
    localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

    tlb_state_t    state_reg;
    tlb_state_t    state_next;
    tlb_op_t       op_reg;
    logic [SW-1:0] starve_cnt_reg;
    logic [31:0]   index_wdata_reg;
    logic [IW-1:0] random_val;

    logic          op_ready_c;
    logic          op_done_c;
    logic          data_grant_c;
    logic          is_tlbp_c;
    logic [1:0]    tlbw_choose_c;
    logic          c0_index_we_c;
    logic          c0_tlbr_we_c;
    logic          tlb_flush_c;

    // Next-state and per-state control outputs.
    always_comb begin
        state_next    = state_reg;
        op_ready_c    = 1'b0;
        op_done_c     = 1'b0;
        data_grant_c  = bus.data_req;
        is_tlbp_c     = 1'b0;
        tlbw_choose_c = TLBW_NONE;
        c0_index_we_c = 1'b0;
        c0_tlbr_we_c  = 1'b0;
        tlb_flush_c   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                op_ready_c = 1'b1;
                if (bus.op_valid) begin
                    case (tlb_op_t'(bus.op_code))
                        OP_TLBP:  state_next = bus.data_req ? ST_WAIT : ST_PROBE;
                        OP_TLBR:  state_next = ST_READ;
                        default:  state_next = ST_WRITE;
                    endcase
                end
            end
            ST_WAIT: begin
                if (!bus.data_req || (starve_cnt_reg == STARVE_LAST)) begin
                    state_next = ST_PROBE;
                end
            end
            ST_PROBE: begin
                data_grant_c = 1'b0;
                is_tlbp_c    = 1'b1;
                state_next   = ST_DONE;
            end
            ST_READ: begin
                c0_tlbr_we_c = 1'b1;
                state_next   = ST_DONE;
            end
            ST_WRITE: begin
                tlbw_choose_c = tlbw_sel(op_reg);
                state_next    = ST_DONE;
            end
            ST_DONE: begin
                op_done_c     = 1'b1;
                c0_index_we_c = (op_reg == OP_TLBP);
                tlb_flush_c   = (op_reg == OP_TLBWI) || (op_reg == OP_TLBWR);
                state_next    = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Latch the instruction kind at acceptance; op_code is ignored afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg <= OP_TLBP;
        end else if ((state_reg == ST_IDLE) && bus.op_valid) begin
            op_reg <= tlb_op_t'(bus.op_code);
        end
    end

    // Starvation counter: counts WAIT cycles, cleared whenever WAIT is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
        end else if ((state_reg == ST_WAIT) && (state_next == ST_WAIT)) begin
            starve_cnt_reg <= starve_cnt_reg + SW'(1);
        end else begin
            starve_cnt_reg <= '0;
        end
    end

    // Capture the probe result at the end of the single PROBE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_wdata_reg <= '0;
        end else if (state_reg == ST_PROBE) begin
            index_wdata_reg <= bus.tlbp_index_in;
        end
    end

    // Random must stay stable while TLBWR is using it.
    tlb_random #(
        .TLBNUM (TLBNUM),
        .IW     (IW)
    ) u_random (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (state_reg == ST_WRITE),
        .wired_we  (bus.wired_we),
        .wired_val (bus.wired_val),
        .random    (random_val)
    );

    assign bus.op_ready       = op_ready_c;
    assign bus.op_done        = op_done_c;
    assign bus.data_grant     = data_grant_c;
    assign bus.is_tlbp        = is_tlbp_c;
    assign bus.tlbw_choose    = tlbw_choose_c;
    assign bus.c0_index_we    = c0_index_we_c;
    assign bus.c0_index_wdata = index_wdata_reg;
    assign bus.c0_tlbr_we     = c0_tlbr_we_c;
    assign bus.tlb_flush      = tlb_flush_c;
    assign bus.c0_random      = {{(32 - IW){1'b0}}, random_val};

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl: a table of single operations with
// expected pulse counts/latencies, plus hand-written multi-cycle sequences.
module tb_tlb_op_ctrl;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    tlb_op_if #(.TLBNUM(16)) bus ();

    tlb_op_ctrl #(
        .TLBNUM     (16),
        .STARVE_MAX (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  code;
        logic        dreq;
        logic [31:0] idx;
        int          lat;
        int          tlbp_n;
        int          tlbr_n;
        int          wr_n;
        logic [1:0]  ch;
        int          idxwe_n;
        logic [31:0] wd;
        int          flush_n;
        int          goff_n;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Issue one operation and tally what the DUT does until op_done.
    task automatic run_vec(input vec_t v, input int vi);
        int lat, tlbp_n, tlbr_n, wr_n, idxwe_n, flush_n, goff_n, rdy_n;
        logic [1:0]  ch;
        logic [31:0] wd;
        bit done;
        lat = 0; tlbp_n = 0; tlbr_n = 0; wr_n = 0; idxwe_n = 0;
        flush_n = 0; goff_n = 0; rdy_n = 0; ch = 2'b00; wd = 32'h0; done = 0;
        @(negedge clk);
        check("pre_ready", {31'd0, bus.op_ready}, 32'd1);
        bus.op_valid      = 1'b1;
        bus.op_code       = v.code;
        bus.data_req      = v.dreq;
        bus.tlbp_index_in = v.idx;
        @(negedge clk);
        bus.op_valid = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            if (c > 1) @(negedge clk);
            if (bus.is_tlbp) tlbp_n++;
            if (bus.c0_tlbr_we) tlbr_n++;
            if (bus.tlbw_choose != 2'b00) begin wr_n++; ch = bus.tlbw_choose; end
            if (bus.c0_index_we) begin idxwe_n++; wd = bus.c0_index_wdata; end
            if (bus.tlb_flush) flush_n++;
            if (bus.data_grant != bus.data_req) goff_n++;
            if (bus.op_ready) rdy_n++;
            if (bus.op_done) begin lat = c; done = 1; end
        end
        $display("vec %0d: op=%0d dreq=%0b lat=%0d tlbp=%0d tlbr=%0d wr=%0d ch=%0d idxwe=%0d wd=0x%08h flush=%0d goff=%0d",
                 vi, v.code, v.dreq, lat, tlbp_n, tlbr_n, wr_n, ch, idxwe_n, wd, flush_n, goff_n);
        check("latency",   lat,     v.lat);
        check("tlbp_cyc",  tlbp_n,  v.tlbp_n);
        check("tlbr_cyc",  tlbr_n,  v.tlbr_n);
        check("write_cyc", wr_n,    v.wr_n);
        check("choose",    {30'd0, ch}, {30'd0, v.ch});
        check("idx_we",    idxwe_n, v.idxwe_n);
        check("idx_wdata", wd,      v.wd);
        check("flush",     flush_n, v.flush_n);
        check("grant_off", goff_n,  v.goff_n);
        check("busy_rdy",  rdy_n,   0);
        bus.data_req = 1'b0;
        @(negedge clk);
        check("post_idle", {31'd0, bus.op_ready}, 32'd1);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n             = 1'b0;
        bus.op_valid      = 1'b0;
        bus.op_code       = 2'b00;
        bus.data_req      = 1'b1;
        bus.tlbp_index_in = 32'h0;
        bus.wired_we      = 1'b0;
        bus.wired_val     = 4'd0;

        //                code   dreq  idx           lat tp tr wr ch     iw wd            fl go
        vecs[0] = '{2'b00, 1'b0, 32'h0000_0005,  2, 1, 0, 0, 2'b00, 1, 32'h0000_0005, 0, 0};
        vecs[1] = '{2'b00, 1'b0, 32'h8000_0000,  2, 1, 0, 0, 2'b00, 1, 32'h8000_0000, 0, 0};
        vecs[2] = '{2'b01, 1'b0, 32'h0000_0003,  2, 0, 1, 0, 2'b00, 0, 32'h0,         0, 0};
        vecs[3] = '{2'b10, 1'b0, 32'h0,          2, 0, 0, 1, 2'b01, 0, 32'h0,         1, 0};
        vecs[4] = '{2'b11, 1'b0, 32'h0,          2, 0, 0, 1, 2'b10, 0, 32'h0,         1, 0};
        vecs[5] = '{2'b00, 1'b1, 32'h0000_000A, 10, 1, 0, 0, 2'b00, 1, 32'h0000_000A, 0, 1};
        vecs[6] = '{2'b01, 1'b1, 32'h0,          2, 0, 1, 0, 2'b00, 0, 32'h0,         0, 0};

        // Reset state.
        @(negedge clk);
        check("rst_ready",  {31'd0, bus.op_ready},    32'd1);
        check("rst_grant",  {31'd0, bus.data_grant},  32'd1);
        check("rst_done",   {31'd0, bus.op_done},     32'd0);
        check("rst_tlbp",   {31'd0, bus.is_tlbp},     32'd0);
        check("rst_choose", {30'd0, bus.tlbw_choose}, 32'd0);
        check("rst_flush",  {31'd0, bus.tlb_flush},   32'd0);
        check("rst_wdata",  bus.c0_index_wdata,       32'd0);
        check("rst_random", bus.c0_random,            32'd15);
        bus.data_req = 1'b0;
        rst_n = 1'b1;
        $display("reset released");

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // TLBR then TLBWI back-to-back; op_code changes during READ must be ignored.
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_code  = 2'b01;
        @(negedge clk);
        bus.op_code = 2'b10;
        check("b2b_c1_tlbr",   {31'd0, bus.c0_tlbr_we},  32'd1);
        check("b2b_c1_ready",  {31'd0, bus.op_ready},    32'd0);
        check("b2b_c1_choose", {30'd0, bus.tlbw_choose}, 32'd0);
        @(negedge clk);
        check("b2b_c2_done",   {31'd0, bus.op_done},     32'd1);
        check("b2b_c2_flush",  {31'd0, bus.tlb_flush},   32'd0);
        check("b2b_c2_tlbr",   {31'd0, bus.c0_tlbr_we},  32'd0);
        check("b2b_c2_ready",  {31'd0, bus.op_ready},    32'd0);
        @(negedge clk);
        check("b2b_c3_ready",  {31'd0, bus.op_ready},    32'd1);
        @(negedge clk);
        bus.op_valid = 1'b0;
        check("b2b_c4_choose", {30'd0, bus.tlbw_choose}, 32'd1);
        check("b2b_c4_tlbr",   {31'd0, bus.c0_tlbr_we},  32'd0);
        @(negedge clk);
        check("b2b_c5_done",   {31'd0, bus.op_done},     32'd1);
        check("b2b_c5_flush",  {31'd0, bus.tlb_flush},   32'd1);
        check("b2b_c5_choose", {30'd0, bus.tlbw_choose}, 32'd0);
        @(negedge clk);
        check("b2b_c6_ready",  {31'd0, bus.op_ready},    32'd1);
        $display("back-to-back TLBR/TLBWI sequence done");

        // TLBWR issued so that Random is 7 during WRITE.
        for (int i = 0; i < 40 && bus.c0_random != 32'd8; i++) @(negedge clk);
        check("wr_find8", bus.c0_random, 32'd8);
        bus.op_valid = 1'b1;
        bus.op_code  = 2'b11;
        @(negedge clk);
        bus.op_valid = 1'b0;
        check("wr_choose", {30'd0, bus.tlbw_choose}, 32'd2);
        check("wr_rand_w", bus.c0_random,            32'd7);
        @(negedge clk);
        check("wr_done",   {31'd0, bus.op_done},     32'd1);
        check("wr_flush",  {31'd0, bus.tlb_flush},   32'd1);
        check("wr_rand_d", bus.c0_random,            32'd7);
        @(negedge clk);
        check("wr_rand_n", bus.c0_random,            32'd6);
        $display("TLBWR with Random=7 done");

        // Wired=4: Random runs 15..5 then wraps.
        bus.wired_we  = 1'b1;
        bus.wired_val = 4'd4;
        @(negedge clk);
        bus.wired_we = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check("wired4_seq", bus.c0_random, (k == 11) ? 32'd15 : 32'(15 - k));
            @(negedge clk);
        end
        check("wired4_pre", bus.c0_random, 32'd14);
        bus.wired_we = 1'b1;
        @(negedge clk);
        bus.wired_we = 1'b0;
        check("wired_we_override", bus.c0_random, 32'd15);
        bus.wired_we  = 1'b1;
        bus.wired_val = 4'd15;
        @(negedge clk);
        bus.wired_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("wired15_hold", bus.c0_random, 32'd15);
            @(negedge clk);
        end
        bus.wired_we  = 1'b1;
        bus.wired_val = 4'd0;
        @(negedge clk);
        bus.wired_we = 1'b0;
        $display("Random/Wired sequence done");

        // Reset asserted while in PROBE.
        @(negedge clk);
        bus.op_valid      = 1'b1;
        bus.op_code       = 2'b00;
        bus.tlbp_index_in = 32'h0000_0033;
        @(negedge clk);
        bus.op_valid = 1'b0;
        check("rp_probe", {31'd0, bus.is_tlbp}, 32'd1);
        #1;
        rst_n        = 1'b0;
        bus.data_req = 1'b1;
        #1;
        check("rp_tlbp",   {31'd0, bus.is_tlbp},    32'd0);
        check("rp_ready",  {31'd0, bus.op_ready},   32'd1);
        check("rp_grant",  {31'd0, bus.data_grant}, 32'd1);
        check("rp_random", bus.c0_random,           32'd15);
        check("rp_wdata",  bus.c0_index_wdata,      32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rp_nodone", {30'd0, bus.op_done, bus.c0_index_we}, 32'd0);
        end
        rst_n        = 1'b1;
        bus.data_req = 1'b0;
        @(negedge clk);
        check("rp_after_done",  {31'd0, bus.op_done},  32'd0);
        check("rp_after_ready", {31'd0, bus.op_ready}, 32'd1);
        check("rp_after_wdata", bus.c0_index_wdata,    32'd0);
        $display("reset during PROBE done");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
